// File: rtl/microwave_ctrl.sv
// Microwave oven control FSM and countdown timer.
//
// Captures one-hot keypad digits into a 3-digit BCD setpoint (M:ST), sequences
// cook / pause / resume / cancel from the start, stop and door inputs, and counts
// the setpoint down once per TICKS_PER_SEC clocks while the magnetron is enabled.
//
// Ports:
//   clk           system clock, rising edge
//   clear         synchronous active-high reset
//   keypad        one-hot digit keys (bit i = digit i), level
//   startn        start button, active-low level
//   stopn         stop/cancel button, active-low level
//   door_closed   1 = door closed
//   mag           magnetron enable (registered state decode)
//   timer_done    one-cycle pulse when the countdown reaches 0:00
//   min_bcd       minutes digit
//   sec_tens_bcd  tens-of-seconds digit
//   sec_ones_bcd  ones-of-seconds digit
//   state         IDLE=0, SET=1, COOK=2, PAUSE=3
module microwave_ctrl #(
    parameter int unsigned TICKS_PER_SEC = 50
) (
    input  logic       clk,
    input  logic       clear,
    input  logic [9:0] keypad,
    input  logic       startn,
    input  logic       stopn,
    input  logic       door_closed,
    output logic       mag,
    output logic       timer_done,
    output logic [3:0] min_bcd,
    output logic [3:0] sec_tens_bcd,
    output logic [3:0] sec_ones_bcd,
    output logic [1:0] state
);

    localparam int unsigned PW = $clog2(TICKS_PER_SEC);
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICKS_PER_SEC - 1);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StSet   = 2'd1,
        StCook  = 2'd2,
        StPause = 2'd3
    } state_e;

    state_e        state_q, state_d;
    logic [3:0]    min_q, min_d, tens_q, tens_d, ones_q, ones_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          done_q, done_d;
    logic          startn_q, stopn_q;
    logic [9:0]    key_q;

    logic       start_ev, stop_ev, key_onehot, key_ev;
    logic [3:0] key_digit;
    logic [3:0] dec_min, dec_tens, dec_ones;
    logic       dec_zero, entry_nonzero;

    assign start_ev   = ~startn & startn_q;
    assign stop_ev    = ~stopn & stopn_q;
    // Exactly one bit set: nonzero and clearing the lowest set bit leaves nothing.
    assign key_onehot = (keypad != 10'd0) && ((keypad & (keypad - 10'd1)) == 10'd0);
    // Event only when the previous sample was all-released, so a held key fires once.
    assign key_ev     = key_onehot && (key_q == 10'd0);

    always_comb begin
        key_digit = 4'd0;
        for (int i = 0; i < 10; i++) begin
            if (keypad[i]) key_digit = 4'(i);
        end
    end

    // Digit-wise decrement; tens above 5 simply count down like any other digit.
    always_comb begin
        dec_min  = min_q;
        dec_tens = tens_q;
        dec_ones = ones_q;
        if (ones_q != 4'd0) begin
            dec_ones = ones_q - 4'd1;
        end else if (tens_q != 4'd0) begin
            dec_tens = tens_q - 4'd1;
            dec_ones = 4'd9;
        end else if (min_q != 4'd0) begin
            dec_min  = min_q - 4'd1;
            dec_tens = 4'd5;
            dec_ones = 4'd9;
        end
    end

    assign dec_zero      = (dec_min == 4'd0) && (dec_tens == 4'd0) && (dec_ones == 4'd0);
    assign entry_nonzero = (tens_q != 4'd0) || (ones_q != 4'd0) || (key_digit != 4'd0);

    always_comb begin
        state_d = state_q;
        min_d   = min_q;
        tens_d  = tens_q;
        ones_d  = ones_q;
        presc_d = presc_q;
        done_d  = 1'b0;

        unique case (state_q)
            StIdle, StSet: begin
                if (state_q == StSet && stop_ev) begin
                    state_d = StIdle;
                    min_d   = 4'd0;
                    tens_d  = 4'd0;
                    ones_d  = 4'd0;
                end else if (state_q == StSet && start_ev && door_closed) begin
                    state_d = StCook;
                    presc_d = '0;
                end else if (key_ev) begin
                    min_d   = tens_q;
                    tens_d  = ones_q;
                    ones_d  = key_digit;
                    state_d = entry_nonzero ? StSet : StIdle;
                end
            end
            StCook: begin
                if (stop_ev || !door_closed) begin
                    state_d = StPause;
                end else if (presc_q == PRESC_MAX) begin
                    presc_d = '0;
                    min_d   = dec_min;
                    tens_d  = dec_tens;
                    ones_d  = dec_ones;
                    if (dec_zero) begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                    end
                end else begin
                    presc_d = presc_q + PW'(1);
                end
            end
            StPause: begin
                if (stop_ev) begin
                    state_d = StIdle;
                    min_d   = 4'd0;
                    tens_d  = 4'd0;
                    ones_d  = 4'd0;
                    presc_d = '0;
                end else if (start_ev && door_closed) begin
                    // Resume mid-second from the held prescaler value.
                    state_d = StCook;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        // Edge-detect samples run through clear so a button held across it is ignored.
        startn_q <= startn;
        stopn_q  <= stopn;
        key_q    <= keypad;
        if (clear) begin
            state_q <= StIdle;
            min_q   <= 4'd0;
            tens_q  <= 4'd0;
            ones_q  <= 4'd0;
            presc_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            min_q   <= min_d;
            tens_q  <= tens_d;
            ones_q  <= ones_d;
            presc_q <= presc_d;
            done_q  <= done_d;
        end
    end

    assign mag          = (state_q == StCook);
    assign timer_done   = done_q;
    assign min_bcd      = min_q;
    assign sec_tens_bcd = tens_q;
    assign sec_ones_bcd = ones_q;
    assign state        = state_q;

endmodule

// File: tb/tb_microwave_ctrl.sv
// Self-checking bench for microwave_ctrl (TICKS_PER_SEC = 4): a vector table, hand
// sequences for the multi-cycle timing cases, and a random phase against a model
// that holds the setpoint as a plain integer (e.g. 199 for 1:99).
module tb_microwave_ctrl;

    localparam int unsigned TPS = 4;

    logic       clk = 1'b0;
    logic       clear, startn, stopn, door_closed;
    logic [9:0] keypad;
    logic       mag, timer_done;
    logic [3:0] min_bcd, sec_tens_bcd, sec_ones_bcd;
    logic [1:0] state;

    int errors = 0;
    int checks = 0;

    microwave_ctrl #(.TICKS_PER_SEC(TPS)) dut (
        .clk         (clk),
        .clear       (clear),
        .keypad      (keypad),
        .startn      (startn),
        .stopn       (stopn),
        .door_closed (door_closed),
        .mag         (mag),
        .timer_done  (timer_done),
        .min_bcd     (min_bcd),
        .sec_tens_bcd(sec_tens_bcd),
        .sec_ones_bcd(sec_ones_bcd),
        .state       (state)
    );

    always #5 clk = ~clk;

    // Reference model: mode 0..3 (IDLE, SET, COOK, PAUSE), setpoint as integer.
    int         m_mode = 0;
    int         m_val = 0;
    int         m_ticks = 0;
    bit         m_done = 0;
    logic       m_sn_q = 1'b1;
    logic       m_stn_q = 1'b1;
    logic [9:0] m_key_q = '0;

    function automatic int dec_val(input int v);
        // Borrowing from the minutes lands on x:59.
        if (v % 100 == 0) return v - 41;
        return v - 1;
    endfunction

    task automatic model_step(input logic c, input logic [9:0] kp, input logic sn,
                              input logic stn, input logic dr);
        bit start_ev, stop_ev, key_ev;
        int d;
        start_ev = !sn && m_sn_q;
        stop_ev  = !stn && m_stn_q;
        key_ev   = ($countones(kp) == 1) && (m_key_q == 10'd0);
        d = 0;
        for (int i = 0; i < 10; i++) if (kp[i]) d = i;
        m_sn_q  = sn;
        m_stn_q = stn;
        m_key_q = kp;
        m_done  = 0;
        if (c) begin
            m_mode = 0; m_val = 0; m_ticks = 0;
        end else begin
            case (m_mode)
                0, 1: begin
                    if (m_mode == 1 && stop_ev) begin
                        m_mode = 0; m_val = 0;
                    end else if (m_mode == 1 && start_ev && dr) begin
                        m_mode = 2; m_ticks = 0;
                    end else if (key_ev) begin
                        m_val  = (m_val % 100) * 10 + d;
                        m_mode = (m_val != 0) ? 1 : 0;
                    end
                end
                2: begin
                    if (stop_ev || !dr) begin
                        m_mode = 3;
                    end else if (m_ticks == TPS - 1) begin
                        m_ticks = 0;
                        m_val   = dec_val(m_val);
                        if (m_val == 0) begin
                            m_mode = 0; m_done = 1;
                        end
                    end else begin
                        m_ticks++;
                    end
                end
                default: begin
                    if (stop_ev) begin
                        m_mode = 0; m_val = 0; m_ticks = 0;
                    end else if (start_ev && dr) begin
                        m_mode = 2;
                    end
                end
            endcase
        end
    endtask

    task automatic step(input logic c, input logic [9:0] kp, input logic sn,
                        input logic stn, input logic dr);
        clear = c; keypad = kp; startn = sn; stopn = stn; door_closed = dr;
        model_step(c, kp, sn, stn, dr);
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [1:0] st, input logic [11:0] dig,
                       input logic mg, input logic dn);
        logic [15:0] act, exp;
        act = {state, min_bcd, sec_tens_bcd, sec_ones_bcd, mag, timer_done};
        exp = {st, dig, mg, dn};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got state=%0d digits=%h mag=%b done=%b, want state=%0d digits=%h mag=%b done=%b",
                     name, state, {min_bcd, sec_tens_bcd, sec_ones_bcd}, mag, timer_done,
                     st, dig, mg, dn);
        end
    endtask

    function automatic logic [9:0] k(input int d);
        logic [9:0] one;
        one = 10'd1;
        return one << d;
    endfunction

    task automatic idle(input int n);
        repeat (n) step(1'b0, 10'd0, 1'b1, 1'b1, 1'b1);
    endtask

    task automatic press(input int d);
        step(1'b0, k(d), 1'b1, 1'b1, 1'b1);
        step(1'b0, 10'd0, 1'b1, 1'b1, 1'b1);
    endtask

    task automatic load(input int a, input int b, input int c);
        step(1'b1, 10'd0, 1'b1, 1'b1, 1'b1);
        press(a); press(b); press(c);
    endtask

    task automatic start_btn();
        step(1'b0, 10'd0, 1'b0, 1'b1, 1'b1);
    endtask

    typedef struct {
        logic       c;
        logic [9:0] kp;
        logic       sn, stn, dr;
        logic [1:0] st;
        logic [11:0] dig;
        logic       mg, dn;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic c, input logic [9:0] kp, input logic sn, input logic stn,
                       input logic dr, input logic [1:0] st, input logic [11:0] dig);
        vec_t v;
        v.c = c; v.kp = kp; v.sn = sn; v.stn = stn; v.dr = dr;
        v.st = st; v.dig = dig; v.mg = 1'b0; v.dn = 1'b0;
        vecs.push_back(v);
    endtask

    initial begin
        // Entry, shift-out, invalid keys, SET start/stop, held key through clear.
        add(1, 10'd0, 1, 1, 1, 0, 12'h000);
        add(0, k(1),  1, 1, 1, 1, 12'h001);
        add(0, 10'd0, 1, 1, 1, 1, 12'h001);
        add(0, k(9),  1, 1, 1, 1, 12'h019);
        add(0, 10'd0, 1, 1, 1, 1, 12'h019);
        add(0, k(9),  1, 1, 1, 1, 12'h199);
        add(0, 10'd0, 1, 1, 1, 1, 12'h199);
        add(0, k(4),  1, 1, 1, 1, 12'h994);
        add(0, 10'd0, 1, 1, 1, 1, 12'h994);
        add(0, 10'b0000000110, 1, 1, 1, 1, 12'h994);
        add(0, 10'd0, 1, 1, 1, 1, 12'h994);
        add(0, 10'd0, 0, 1, 0, 1, 12'h994);
        add(0, 10'd0, 1, 1, 1, 1, 12'h994);
        add(0, 10'd0, 1, 0, 1, 0, 12'h000);
        add(0, 10'd0, 1, 1, 1, 0, 12'h000);
        add(0, k(5),  1, 1, 1, 1, 12'h005);
        add(0, 10'd0, 1, 1, 1, 1, 12'h005);
        add(0, 10'd0, 0, 0, 1, 0, 12'h000);
        add(0, 10'd0, 1, 1, 1, 0, 12'h000);
        add(0, k(0),  1, 1, 1, 0, 12'h000);
        add(0, 10'd0, 1, 1, 1, 0, 12'h000);
        add(0, k(3),  1, 1, 1, 1, 12'h003);
        add(0, 10'd0, 1, 1, 1, 1, 12'h003);
        add(1, k(7),  1, 1, 1, 0, 12'h000);
        add(0, k(7),  1, 1, 1, 0, 12'h000);
        add(0, 10'd0, 1, 1, 1, 0, 12'h000);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].c, vecs[i].kp, vecs[i].sn, vecs[i].stn, vecs[i].dr);
            chk($sformatf("vec%0d", i), vecs[i].st, vecs[i].dig, vecs[i].mg, vecs[i].dn);
        end

        // 1:99 counts to 1:98 four cycles after the start edge.
        load(1, 9, 9);
        start_btn();
        chk("cook_start", 2, 12'h199, 1, 0);
        idle(3);
        chk("cook_pre_tick", 2, 12'h199, 1, 0);
        idle(1);
        chk("cook_tick_199", 2, 12'h198, 1, 0);

        // Minute borrow.
        load(1, 0, 0);
        start_btn();
        idle(4);
        chk("borrow_100", 2, 12'h059, 1, 0);

        // Completion pulse.
        load(0, 0, 2);
        start_btn();
        idle(7);
        chk("done_minus1", 2, 12'h001, 1, 0);
        idle(1);
        chk("done_edge", 0, 12'h000, 0, 1);
        idle(1);
        chk("done_pulse_end", 0, 12'h000, 0, 0);

        // Door pause mid-second, door close alone, resume from held prescaler.
        load(0, 0, 5);
        start_btn();
        idle(4);
        chk("pause_first_tick", 2, 12'h004, 1, 0);
        idle(2);
        step(1'b0, 10'd0, 1'b1, 1'b1, 1'b0);
        chk("door_open_pause", 3, 12'h004, 0, 0);
        idle(10);
        chk("door_closed_hold", 3, 12'h004, 0, 0);
        start_btn();
        chk("resume", 2, 12'h004, 1, 0);
        idle(1);
        chk("resume_pre_tick", 2, 12'h004, 1, 0);
        idle(1);
        chk("resume_tick", 2, 12'h003, 1, 0);
        step(1'b0, 10'd0, 1'b1, 1'b0, 1'b1);
        chk("cook_stop_pause", 3, 12'h003, 0, 0);
        idle(1);
        step(1'b0, 10'd0, 1'b1, 1'b0, 1'b1);
        chk("pause_stop_idle", 0, 12'h000, 0, 0);
        idle(1);

        // startn held low across clear never starts.
        step(1'b1, 10'd0, 1'b0, 1'b1, 1'b1);
        step(1'b0, k(3), 1'b0, 1'b1, 1'b1);
        step(1'b0, 10'd0, 1'b0, 1'b1, 1'b1);
        step(1'b0, 10'd0, 1'b0, 1'b1, 1'b1);
        chk("held_start", 1, 12'h003, 0, 0);
        idle(1);

        // clear mid-cook.
        load(0, 0, 9);
        start_btn();
        idle(2);
        step(1'b1, 10'd0, 1'b1, 1'b1, 1'b1);
        chk("clear_mid_cook", 0, 12'h000, 0, 0);

        // Random stimulus against the model.
        for (int n = 0; n < 3000; n++) begin
            logic [9:0] kp;
            int r;
            r = int'($urandom_range(0, 9));
            if (r < 4)       kp = k(int'($urandom_range(0, 9)));
            else if (r == 4) kp = 10'($urandom);
            else             kp = 10'd0;
            step($urandom_range(0, 299) == 0, kp, $urandom_range(0, 5) != 0,
                 $urandom_range(0, 39) != 0, $urandom_range(0, 15) != 0);
            chk("rand", 2'(m_mode),
                {4'(m_val / 100), 4'((m_val / 10) % 10), 4'(m_val % 10)}, m_mode == 2, m_done);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/microwave_ctrl.md
Name: microwave_ctrl

Overview:
Control FSM and timer datapath for the microwave oven. Captures one-hot keypad digits into a 3-digit BCD setpoint (M:ST). Sequences cook / pause / resume / cancel against the start, stop and door-interlock inputs, and counts the setpoint down once per second while driving the magnetron enable. Outputs raw BCD digits for the existing 7-segment decoders.

Parameters:
TICKS_PER_SEC, 50, clk cycles per one-second decrement (50 Hz system clock); must be >= 2

Ports:
clk  input  1  system clock, rising edge
clear  input  1  reset, synchronous, active-high
keypad  input  10  one-hot digit keys, bit i = digit i, level
startn  input  1  start button, active-low level
stopn  input  1  stop/cancel button, active-low level
door_closed  input  1  1 = door closed
mag  output  1  magnetron enable
timer_done  output  1  one-cycle pulse on countdown completion
min_bcd  output  4  minutes digit
sec_tens_bcd  output  4  tens-of-seconds digit
sec_ones_bcd  output  4  ones-of-seconds digit
state  output  2  IDLE=0, SET=1, COOK=2, PAUSE=3

Behaviour:
- Reset (clear=1 at an edge): state=IDLE, all digits 0, mag=0, timer_done=0, prescaler=0.
- Edge detectors: startn_q, stopn_q and key_q sample their inputs every cycle, including during clear. A button or key held through clear produces no event.
- start event: startn=0 and startn_q=1. stop event: stopn=0 and stopn_q=1.
- Key event: keypad has exactly one bit set and key_q==0. Zero-hot or multi-hot patterns produce no event.
- Every event acts at the same edge it is sampled: 1-cycle latency to state/outputs.
- Digit entry, valid only in IDLE or SET: min<=tens, tens<=ones, ones<=digit. The oldest digit is discarded.
  - Any entry leaving a nonzero value -> SET. Entering 0 from IDLE stays IDLE at 000.
- Digit range: tens may hold 6..9, e.g. 1:99. Counting still proceeds digit-wise (see decrement).
- mag = (state==COOK), decoded from the state register; no combinational path from inputs.
- Event priority each cycle: clear > stop > door open > start > tick > key.
- IDLE: key -> entry. start and stop ignored.
- SET:
  - key -> entry.
  - stop -> digits 000, IDLE.
  - start with door_closed=1 -> COOK, prescaler=0.
  - start with door open ignored.
- COOK:
  - Prescaler increments each cycle. At TICKS_PER_SEC-1 it wraps to 0 and the digits decrement.
  - door_closed=0 -> PAUSE at that edge, with no decrement even if the tick coincides.
  - stop -> PAUSE.
  - Keys ignored.
- Decrement rule:
  - if ones>0: ones-1;
  - else if tens>0: tens-1, ones=9;
  - else if min>0: min-1, tens=5, ones=9.
  - Example: 1:00 -> 0:59.
- Completion: a decrement whose result is 000 -> IDLE, and timer_done=1 for exactly that one cycle.
- PAUSE:
  - Prescaler and digits hold.
  - start with door_closed=1 -> COOK, resuming from the held prescaler value.
  - start with door open ignored.
  - stop -> digits 000, prescaler 0, IDLE.
  - Keys ignored.
  - Closing the door alone does not resume.
- start and stop in the same cycle: stop wins.
- Door open in IDLE or SET: only blocks start.
- clear mid-COOK: mag=0 and digits 000 at that edge.

Test Plan:
Use TICKS_PER_SEC=4 throughout.
1. clear; keys 1,9,9 (one cycle each, released between) -> digits 1/9/9, state=SET, mag=0. Then key 4 -> 9/9/4 (oldest dropped).
2. Load 1:99; start with door closed -> mag=1 at next edge. After 4 cycles: 1:98. Preload 1:00 -> 4 cycles later 0:59.
3. Load 002; start -> after 8 cycles digits 000, state=IDLE, mag=0, timer_done high exactly 1 cycle.
4. Load 005; start; open door 2 cycles after a decrement -> PAUSE, mag=0, digits hold 0:04.
   - Close door, no start for 10 cycles -> still PAUSE.
   - start -> COOK; next decrement 2 cycles later (0:03).
5. In SET: start with door_closed=0 -> stays SET. stop -> 000 IDLE. In PAUSE: stop -> 000 IDLE. start and stop in the same cycle from SET -> IDLE.
6. keypad=10'b0000000110 -> no change. Hold startn=0 across clear -> no COOK after release. clear asserted mid-COOK -> all outputs 0 at that edge.
